// File: rtl/ref_window_loader.sv
// Reference window loader: buffers a raster-order W x W pixel window and replays it as
// NUM_PIXEL parallel 8-tap vectors per row (then per column when VERTICAL_PASS_EN is defined).
module ref_window_loader #(
    parameter int NUM_PIXEL = 8,
    parameter int PIXEL_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           abort,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PIXEL_W-1:0]             in_pixel,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_PIXEL*8*PIXEL_W-1:0] out_taps,
    output logic [3:0]                     out_idx,
    output logic                           out_dir,
    output logic                           out_last
);

    localparam int         W      = NUM_PIXEL + 7;
    localparam int         LANE_W = 8 * PIXEL_W;
    localparam logic [3:0] LAST   = 4'(W - 1);

`ifdef VERTICAL_PASS_EN
    typedef enum logic [1:0] {S_LOAD, S_EMIT_R, S_EMIT_C} state_t;
`else
    typedef enum logic [1:0] {S_LOAD, S_EMIT_R} state_t;
`endif

    state_t                           r_state;
    logic [PIXEL_W-1:0]               r_pix [W][W];
    logic [3:0]                       r_wr_row;
    logic [3:0]                       r_wr_col;
    logic [3:0]                       r_idx;
    logic                             r_in_ready;
    logic                             r_out_valid;
    logic [NUM_PIXEL*8*PIXEL_W-1:0]   r_taps;
    logic                             r_last;

    logic                             w_in_acc;
    logic                             w_out_hs;
    logic                             w_last_pix;
    logic [3:0]                       w_nidx;
    logic [NUM_PIXEL*8*PIXEL_W-1:0]   w_row_taps;

    assign w_in_acc   = in_valid & r_in_ready;
    assign w_out_hs   = r_out_valid & out_ready;
    assign w_last_pix = (r_wr_row == LAST) && (r_wr_col == LAST);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_taps  = r_taps;
    assign out_idx   = r_idx;
    assign out_last  = r_last;

    // Index of the beat to present after this edge: held on stall/bubble, advanced on handshake
    always_comb begin
        w_nidx = r_idx;
        if (w_out_hs)
            w_nidx = (r_idx == LAST) ? '0 : r_idx + 4'd1;
    end

    always_comb begin
        w_row_taps = '0;
        for (int unsigned i = 0; i < NUM_PIXEL; i++)
            for (int unsigned k = 0; k < 8; k++)
                w_row_taps[i*LANE_W + k*PIXEL_W +: PIXEL_W] = r_pix[w_nidx][4'(i + k)];
    end

`ifdef VERTICAL_PASS_EN
    logic                             r_dir;
    logic [NUM_PIXEL*8*PIXEL_W-1:0]   w_col_taps;

    assign out_dir = r_dir;

    always_comb begin
        w_col_taps = '0;
        for (int unsigned i = 0; i < NUM_PIXEL; i++)
            for (int unsigned k = 0; k < 8; k++)
                w_col_taps[i*LANE_W + k*PIXEL_W +: PIXEL_W] = r_pix[4'(i + k)][w_nidx];
    end
`else
    assign out_dir = 1'b0;
`endif

    // Window storage is never cleared; each load overwrites every location
    always_ff @(posedge clk) begin
        if (!abort && r_state == S_LOAD && w_in_acc)
            r_pix[r_wr_row][r_wr_col] <= in_pixel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LOAD;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_taps      <= '0;
            r_last      <= 1'b0;
`ifdef VERTICAL_PASS_EN
            r_dir       <= 1'b0;
`endif
        end else if (abort) begin
            r_state     <= S_LOAD;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
`ifdef VERTICAL_PASS_EN
            r_dir       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_in_acc) begin
                        if (w_last_pix) begin
                            r_wr_row   <= '0;
                            r_wr_col   <= '0;
                            r_idx      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_EMIT_R;
                        end else if (r_wr_col == LAST) begin
                            r_wr_col <= '0;
                            r_wr_row <= r_wr_row + 4'd1;
                        end else begin
                            r_wr_col <= r_wr_col + 4'd1;
                        end
                    end
                end

                // First cycle here (out_valid low) is the bubble that registers row 0
                S_EMIT_R: begin
                    if (!r_out_valid || w_out_hs) begin
                        if (w_out_hs && r_idx == LAST) begin
`ifdef VERTICAL_PASS_EN
                            r_state <= S_EMIT_C;
                            r_idx   <= '0;
                            r_taps  <= w_col_taps;
                            r_dir   <= 1'b1;
                            r_last  <= 1'b0;
`else
                            r_state     <= S_LOAD;
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_last      <= 1'b0;
`endif
                        end else begin
                            r_out_valid <= 1'b1;
                            r_idx       <= w_nidx;
                            r_taps      <= w_row_taps;
`ifdef VERTICAL_PASS_EN
                            r_last      <= 1'b0;
`else
                            r_last      <= (w_nidx == LAST);
`endif
                        end
                    end
                end

`ifdef VERTICAL_PASS_EN
                S_EMIT_C: begin
                    if (w_out_hs) begin
                        if (r_idx == LAST) begin
                            r_state     <= S_LOAD;
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_dir       <= 1'b0;
                            r_last      <= 1'b0;
                        end else begin
                            r_idx  <= w_nidx;
                            r_taps <= w_col_taps;
                            r_last <= (w_nidx == LAST);
                        end
                    end
                end
`endif

                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule
